// File: rtl/fifo_drain_streamer.sv
// -----------------------------------------------------------------------------
// fifo_drain_streamer
//
// Purpose:
//   Drains words from a synchronous FIFO (read-enable / empty / registered
//   read data with one cycle of latency). It re-presents them as a
//   valid/ready stream. m_last_o is asserted on every BURST_LEN-th beat.
//   A 2-entry output buffer absorbs the FIFO read latency and any
//   backpressure from the sink.
//
// Parameters:
//   DATA_WIDTH  width of FIFO words and stream data
//   BURST_LEN   beats per burst (1..256); m_last_o marks beat BURST_LEN-1
//   CNT_BITS    beat counter width, 2**CNT_BITS >= BURST_LEN
//
// Ports:
//   clk_i           single clock, rising edge
//   reset_i         synchronous active-high reset
//   fifo_empty_i    FIFO empty flag
//   fifo_data_i     FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_rd_en_o    FIFO read request, one word per high cycle
//   m_valid_o       output beat valid
//   m_ready_i       sink ready
//   m_data_o        output beat data
//   m_last_o        last beat of the current burst
//   busy_o          buffer non-empty or a read in flight
//
// Optional build macro:
//   FIFO_DRAIN_STATS_EN  adds beat_total_o (transfers, wrapping) and
//                        stall_cycles_o (valid && !ready cycles, saturating)
// -----------------------------------------------------------------------------
module fifo_drain_streamer #(
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 8,
   parameter int CNT_BITS   = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   output logic                  fifo_rd_en_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_last_o,
   output logic                  busy_o
`ifdef FIFO_DRAIN_STATS_EN
   ,
   output logic [31:0]           beat_total_o,
   output logic [31:0]           stall_cycles_o
`endif
);

   // Beat index that carries the last flag, truncated to the counter width.
   localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BURST_LEN - 1);

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_DATA = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   state_t                state_reg;
   state_t                state_next;
   logic                  inflight_reg;
   logic                  inflight_next;
   logic                  rd_en;

   logic [DATA_WIDTH-1:0] mem_reg [2];
   logic                  head_reg;
   logic [1:0]            count_reg;
   logic [1:0]            count_next;
   logic                  tail_idx;

   logic [CNT_BITS-1:0]   beat_cnt_reg;

   logic                  has_room;
   logic                  capture;
   logic                  valid;
   logic                  xfer;
   logic                  last_beat;

   // ---------------------------------------------------------------------------
   // Handshake and buffer bookkeeping
   // ---------------------------------------------------------------------------
   // A new read may only be issued if the word it returns is guaranteed a
   // slot. That slot must exist even if the sink never takes anything.
   assign has_room  = ({1'b0, count_reg} + {2'b00, inflight_reg}) < 3'd2;

   // The word requested in the IDLE cycle appears on fifo_data_i during
   // WAIT_DATA. It is written into the buffer at the end of that cycle.
   assign capture   = (state_reg == WAIT_DATA);

   assign valid     = (count_reg != 2'd0);
   assign xfer      = valid && m_ready_i;
   assign last_beat = (beat_cnt_reg == LAST_BEAT);

   // Slot after the last occupied one. With 2 entries this is head+count mod 2.
   assign tail_idx  = head_reg ^ count_reg[0];

   always_comb begin
      count_next = count_reg;
      case ({capture, xfer})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Read FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg    <= IDLE;
         inflight_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         inflight_reg <= inflight_next;
      end
   end

   // The read request is decoded from the registered IDLE state in the
   // same cycle the FIFO samples it. This lets the data land exactly in
   // WAIT_DATA. Because reads are never issued from WAIT_DATA, the empty
   // flag seen in IDLE already reflects the previous pop.
   always_comb begin
      state_next    = state_reg;
      inflight_next = inflight_reg;
      rd_en         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!reset_i && !fifo_empty_i && has_room) begin
               rd_en         = 1'b1;
               state_next    = WAIT_DATA;
               inflight_next = 1'b1;
            end
         end
         WAIT_DATA: begin
            state_next    = IDLE;
            inflight_next = 1'b0;
         end
         default: begin
            state_next    = IDLE;
            inflight_next = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_reg  <= 1'b0;
         count_reg <= 2'd0;
      end else begin
         count_reg <= count_next;
         if (xfer) begin
            head_reg <= ~head_reg;
         end
      end
   end

   // Storage is only written at the tail, so the head entry stays
   // untouched while the sink stalls.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < 2; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (capture) begin
         mem_reg[tail_idx] <= fifo_data_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Burst framing
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         beat_cnt_reg <= '0;
      end else if (xfer) begin
         if (last_beat) begin
            beat_cnt_reg <= '0;
         end else begin
            beat_cnt_reg <= beat_cnt_reg + CNT_BITS'(1);
         end
      end
   end

`ifndef SYNTHESIS
   // A capture into a full buffer without a simultaneous pop means the
   // room check failed; the incoming word would overwrite the head.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(capture && !xfer && (count_reg == 2'd2)));
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Optional statistics
   // ---------------------------------------------------------------------------
`ifdef FIFO_DRAIN_STATS_EN
   logic [31:0] beat_total_reg;
   logic [31:0] stall_cycles_reg;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         beat_total_reg   <= 32'd0;
         stall_cycles_reg <= 32'd0;
      end else begin
         if (xfer) begin
            beat_total_reg <= beat_total_reg + 32'd1;
         end
         // Saturate so a long stall cannot roll back to a small value.
         if (valid && !m_ready_i && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         end
      end
   end

   assign beat_total_o   = beat_total_reg;
   assign stall_cycles_o = stall_cycles_reg;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign fifo_rd_en_o = rd_en;
   assign m_valid_o    = valid;
   assign m_data_o     = mem_reg[head_reg];
   assign m_last_o     = valid && last_beat;
   assign busy_o       = valid || inflight_reg;

endmodule

// File: tb/tb_fifo_drain_streamer.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_streamer
//
// Directed bench for fifo_drain_streamer (DATA_WIDTH=32, BURST_LEN=8).
// A small FIFO model returns registered read data one cycle after
// fifo_rd_en_o. A negedge monitor logs every accepted beat with its
// cycle stamp. Each scenario task compares the log against
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_fifo_drain_streamer;

   localparam int DW = 32;

   logic          clk_i       = 1'b0;
   logic          reset_i     = 1'b1;
   logic          m_ready_i   = 1'b0;
   logic          fifo_empty_i;
   logic [DW-1:0] fifo_data_i = '0;
   logic          fifo_rd_en_o;
   logic          m_valid_o;
   logic [DW-1:0] m_data_o;
   logic          m_last_o;
   logic          busy_o;
`ifdef FIFO_DRAIN_STATS_EN
   logic [31:0]   beat_total_o;
   logic [31:0]   stall_cycles_o;
`endif

   always #5 clk_i = ~clk_i;

   fifo_drain_streamer #(
      .DATA_WIDTH (DW),
      .BURST_LEN  (8),
      .CNT_BITS   (8)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .fifo_empty_i   (fifo_empty_i),
      .fifo_data_i    (fifo_data_i),
      .fifo_rd_en_o   (fifo_rd_en_o),
      .m_valid_o      (m_valid_o),
      .m_ready_i      (m_ready_i),
      .m_data_o       (m_data_o),
      .m_last_o       (m_last_o),
      .busy_o         (busy_o)
`ifdef FIFO_DRAIN_STATS_EN
      ,
      .beat_total_o   (beat_total_o),
      .stall_cycles_o (stall_cycles_o)
`endif
   );

   // ---------------------------------------------------------------------------
   // FIFO model: words are preloaded into src_mem by the stimulus
   // ---------------------------------------------------------------------------
   logic [DW-1:0] src_mem [512];
   int            wr_count       = 0;
   int            rd_ptr         = 0;
   logic          fifo_clr       = 1'b1;
   logic          underflow_seen = 1'b0;

   assign fifo_empty_i = (rd_ptr >= wr_count);

   always @(posedge clk_i) begin
      if (fifo_clr) begin
         rd_ptr      <= 0;
         fifo_data_i <= '0;
      end else if (fifo_rd_en_o) begin
         if (rd_ptr >= wr_count) begin
            underflow_seen <= 1'b1;
         end else begin
            fifo_data_i <= src_mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Beat monitor
   // ---------------------------------------------------------------------------
   int            cyc   = 0;
   int            n_got = 0;
   logic [DW-1:0] got_data [256];
   logic          got_last [256];
   int            got_cyc  [256];

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (!reset_i && m_valid_o && m_ready_i && n_got < 256) begin
         got_data[n_got] <= m_data_o;
         got_last[n_got] <= m_last_o;
         got_cyc[n_got]  <= cyc;
         n_got           <= n_got + 1;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic do_reset();
      reset_i   = 1'b1;
      fifo_clr  = 1'b1;
      wr_count  = 0;
      m_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      reset_i  = 1'b0;
      fifo_clr = 1'b0;
   endtask

   task automatic push_words(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         src_mem[wr_count] = base + DW'(i);
         wr_count++;
      end
   endtask

   task automatic wait_beats(input int target, input int budget);
      for (int t = 0; t < budget && n_got < target; t++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      int seen;
      do_reset();
      @(negedge clk_i);
      n_checks++; if (fifo_rd_en_o !== 1'b0) $display("FAIL reset_rd_en: got %0b want 0", fifo_rd_en_o); else n_pass++;
      n_checks++; if (m_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b want 0", m_valid_o); else n_pass++;
      n_checks++; if (m_data_o !== '0) $display("FAIL reset_data: got %08h want 0", m_data_o); else n_pass++;
      n_checks++; if (m_last_o !== 1'b0) $display("FAIL reset_last: got %0b want 0", m_last_o); else n_pass++;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy_o); else n_pass++;
      seen = 0;
      repeat (6) begin
         @(negedge clk_i);
         if (fifo_rd_en_o !== 1'b0) seen++;
      end
      n_checks++; if (seen != 0) $display("FAIL rd_en_while_empty: got %0d reads want 0", seen); else n_pass++;
      $display("test_reset done");
   endtask

   task automatic test_stream8();
      int base;
      int bad;
      base = n_got;
      m_ready_i = 1'b1;
      push_words(8, 32'h0);
      wait_beats(base + 8, 100);
      n_checks++; if (n_got != base + 8) $display("FAIL stream8_count: got %0d want %0d", n_got - base, 8); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (got_data[base+i] !== DW'(i)) $display("FAIL stream8_data[%0d]: got %08h want %08h", i, got_data[base+i], i); else n_pass++;
         n_checks++; if (got_last[base+i] !== (i == 7)) $display("FAIL stream8_last[%0d]: got %0b want %0b", i, got_last[base+i], (i == 7)); else n_pass++;
         $display("stream8 beat %0d data=%08h last=%0b", i, got_data[base+i], got_last[base+i]);
      end
      bad = 0;
      for (int i = 1; i < 8; i++) begin
         if (got_cyc[base+i] - got_cyc[base+i-1] != 2) bad++;
      end
      n_checks++; if (bad != 0) $display("FAIL stream8_spacing: got %0d gaps not equal 2 want 0", bad); else n_pass++;
      @(negedge clk_i);
      n_checks++; if (busy_o !== 1'b0) $display("FAIL stream8_busy_end: got %0b want 0", busy_o); else n_pass++;
      n_checks++; if (m_valid_o !== 1'b0) $display("FAIL stream8_valid_end: got %0b want 0", m_valid_o); else n_pass++;
   endtask

   task automatic test_backpressure();
      int base;
      int rbase;
      int bad_rd;
      int bad_hold;
      base  = n_got;
      rbase = rd_ptr;
      @(posedge clk_i);
      #1;
      m_ready_i = 1'b0;
      push_words(10, 32'h0);
      bad_rd   = 0;
      bad_hold = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (i >= 4 && fifo_rd_en_o !== 1'b0) bad_rd++;
         if (i >= 2 && (m_valid_o !== 1'b1 || m_data_o !== '0 || m_last_o !== 1'b0)) bad_hold++;
      end
      n_checks++; if (rd_ptr - rbase != 2) $display("FAIL bp_reads_issued: got %0d want 2", rd_ptr - rbase); else n_pass++;
      n_checks++; if (bad_rd != 0) $display("FAIL bp_rd_en_held: got %0d high cycles want 0", bad_rd); else n_pass++;
      n_checks++; if (bad_hold != 0) $display("FAIL bp_data_hold: got %0d unstable cycles want 0", bad_hold); else n_pass++;
      @(posedge clk_i);
      #1;
      m_ready_i = 1'b1;
      wait_beats(base + 10, 100);
      n_checks++; if (n_got != base + 10) $display("FAIL bp_count: got %0d want 10", n_got - base); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (got_data[base+i] !== DW'(i)) $display("FAIL bp_data[%0d]: got %08h want %08h", i, got_data[base+i], i); else n_pass++;
         n_checks++; if (got_last[base+i] !== (i == 7)) $display("FAIL bp_last[%0d]: got %0b want %0b", i, got_last[base+i], (i == 7)); else n_pass++;
         $display("bp beat %0d data=%08h last=%0b", i, got_data[base+i], got_last[base+i]);
      end
      @(negedge clk_i);
      n_checks++; if (dut.beat_cnt_reg !== 8'd2) $display("FAIL bp_beat_cnt: got %0d want 2", dut.beat_cnt_reg); else n_pass++;
   endtask

   task automatic test_alternating();
      int base;
      logic [DW-1:0] exp;
      do_reset();
      base = n_got;
      push_words(24, 32'h200);
      m_ready_i = 1'b1;
      for (int t = 0; t < 400 && n_got < base + 24; t++) begin
         @(posedge clk_i);
         #1;
         m_ready_i = ~m_ready_i;
      end
      n_checks++; if (n_got != base + 24) $display("FAIL alt_count: got %0d want 24", n_got - base); else n_pass++;
      for (int i = 0; i < 24; i++) begin
         exp = 32'h200 + DW'(i);
         n_checks++; if (got_data[base+i] !== exp) $display("FAIL alt_data[%0d]: got %08h want %08h", i, got_data[base+i], exp); else n_pass++;
         n_checks++; if (got_last[base+i] !== ((i % 8) == 7)) $display("FAIL alt_last[%0d]: got %0b want %0b", i, got_last[base+i], ((i % 8) == 7)); else n_pass++;
         $display("alt beat %0d data=%08h last=%0b", i, got_data[base+i], got_last[base+i]);
      end
      m_ready_i = 1'b1;
      repeat (10) @(posedge clk_i);
      #1;
      n_checks++; if (n_got != base + 24) $display("FAIL alt_no_dup: got %0d beats want 24", n_got - base); else n_pass++;
      n_checks++; if (rd_ptr != 24) $display("FAIL alt_reads: got %0d want 24", rd_ptr); else n_pass++;
   endtask

   task automatic test_reset_midstream();
      int  base;
      logic found;
      logic [DW-1:0] exp;
      do_reset();
      push_words(20, 32'h300);
      found = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk_i);
         if (m_valid_o === 1'b1 && fifo_rd_en_o === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++; if (found !== 1'b1) $display("FAIL mid_setup: got %0b want 1", found); else n_pass++;
      // Next cycle: one word buffered and the second read in flight.
      @(posedge clk_i);
      #1;
      reset_i  = 1'b1;
      fifo_clr = 1'b1;
      wr_count = 0;
      @(posedge clk_i);
      #1;
      reset_i  = 1'b0;
      fifo_clr = 1'b0;
      @(negedge clk_i);
      n_checks++; if (m_valid_o !== 1'b0) $display("FAIL mid_valid: got %0b want 0", m_valid_o); else n_pass++;
      n_checks++; if (m_data_o !== '0) $display("FAIL mid_data: got %08h want 0", m_data_o); else n_pass++;
      n_checks++; if (m_last_o !== 1'b0) $display("FAIL mid_last: got %0b want 0", m_last_o); else n_pass++;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL mid_busy: got %0b want 0", busy_o); else n_pass++;
      n_checks++; if (fifo_rd_en_o !== 1'b0) $display("FAIL mid_rd_en: got %0b want 0", fifo_rd_en_o); else n_pass++;
      base = n_got;
      m_ready_i = 1'b1;
      push_words(10, 32'h400);
      wait_beats(base + 10, 100);
      n_checks++; if (n_got != base + 10) $display("FAIL mid_count: got %0d want 10", n_got - base); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         exp = 32'h400 + DW'(i);
         n_checks++; if (got_data[base+i] !== exp) $display("FAIL mid_data[%0d]: got %08h want %08h", i, got_data[base+i], exp); else n_pass++;
         n_checks++; if (got_last[base+i] !== (i == 7)) $display("FAIL mid_last[%0d]: got %0b want %0b", i, got_last[base+i], (i == 7)); else n_pass++;
         $display("mid beat %0d data=%08h last=%0b", i, got_data[base+i], got_last[base+i]);
      end
   endtask

`ifdef FIFO_DRAIN_STATS_EN
   task automatic test_stats();
      int base;
      logic found;
      do_reset();
      @(negedge clk_i);
      n_checks++; if (beat_total_o !== 32'd0) $display("FAIL stats_beats_rst: got %0d want 0", beat_total_o); else n_pass++;
      n_checks++; if (stall_cycles_o !== 32'd0) $display("FAIL stats_stall_rst: got %0d want 0", stall_cycles_o); else n_pass++;
      base = n_got;
      push_words(16, 32'h500);
      found = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk_i);
         if (m_valid_o === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++; if (found !== 1'b1) $display("FAIL stats_valid_seen: got %0b want 1", found); else n_pass++;
      // Five edges with valid high and ready low, then ready stays high.
      repeat (5) @(posedge clk_i);
      #1;
      m_ready_i = 1'b1;
      wait_beats(base + 16, 200);
      @(negedge clk_i);
      n_checks++; if (beat_total_o !== 32'd16) $display("FAIL stats_beats: got %0d want 16", beat_total_o); else n_pass++;
      n_checks++; if (stall_cycles_o !== 32'd5) $display("FAIL stats_stall: got %0d want 5", stall_cycles_o); else n_pass++;
      do_reset();
      @(negedge clk_i);
      n_checks++; if (beat_total_o !== 32'd0) $display("FAIL stats_beats_clr: got %0d want 0", beat_total_o); else n_pass++;
      n_checks++; if (stall_cycles_o !== 32'd0) $display("FAIL stats_stall_clr: got %0d want 0", stall_cycles_o); else n_pass++;
   endtask
`endif

   task automatic test_no_underflow();
      n_checks++; if (underflow_seen !== 1'b0) $display("FAIL no_underflow: got %0b want 0", underflow_seen); else n_pass++;
   endtask

   // ---------------------------------------------------------------------------
   // Sequence
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_stream8();
      test_backpressure();
      test_alternating();
      test_reset_midstream();
`ifdef FIFO_DRAIN_STATS_EN
      test_stats();
`endif
      test_no_underflow();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
